// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scheduler and its BCD engine.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } seg_state_e;

  localparam int         BCD_W       = 16;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // One double-dabble correction step: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[i*4 +: 4] >= ADD3_THRESH) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Bundle between the debug taps / switches and the display scheduler.
interface seg_display_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int VAL_W   = 13
);
  import seg_pkg::*;

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Handshake: all inputs are level-sampled every clk with no backpressure;
  // digits is valid at all times and upd is a one-cycle qualifier marking a new word.
  logic [NUM_SRC*VAL_W-1:0] src_val;
  logic [NUM_SRC-1:0]       src_valid;
  logic                     mode_auto;
  logic [SEL_W-1:0]         sel_manual;
  logic                     step;
  logic [BCD_W-1:0]         digits;
  logic [SEL_W-1:0]         cur_src;
  logic                     blank;
  logic                     busy;
  logic                     upd;
  seg_state_e               dbg_state;

  modport master (
    output src_val, src_valid, mode_auto, sel_manual, step,
    input  digits, cur_src, blank, busy, upd, dbg_state
  );

  modport slave (
    input  src_val, src_valid, mode_auto, sel_manual, step,
    output digits, cur_src, blank, busy, upd, dbg_state
  );

endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble converter: one LOAD, VAL_W SHIFT cycles, one COMMIT.
module bcd_seq_conv
  import seg_pkg::*;
#(
  parameter int VAL_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output seg_state_e       state,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] digits
);

  localparam int               IT_W      = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(VAL_W - 1);

  seg_state_e                  state_q, state_d;
  logic [BCD_W+VAL_W-1:0]      shift_q;
  logic [IT_W-1:0]             iter_q;
  logic [BCD_W-1:0]            digits_q;
  logic                        done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (iter_q == ITER_LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        LOAD: begin
          shift_q <= {{BCD_W{1'b0}}, value};
          iter_q  <= '0;
        end
        SHIFT: begin
          shift_q <= {add3_adjust(shift_q[VAL_W +: BCD_W]), shift_q[VAL_W-1:0]} << 1;
          iter_q  <= iter_q + 1'b1;
        end
        // The output word only ever changes here, so the driver never sees a partial result.
        COMMIT: begin
          digits_q <= shift_q[VAL_W +: BCD_W];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state  = state_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign digits = digits_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Display scheduler: picks a debug source (manual or timed round-robin) and feeds it to the BCD engine.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VAL_W   = 13,
  parameter int DWELL   = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  seg_display_ctrl_if.slave sif
);

  localparam int              SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] cur_src, last_src, next_src, cand;
  logic [CNT_W-1:0] dwell_cnt;
  logic             blank, advance, start, found;
  logic [VAL_W-1:0] cur_val, snapshot;
  seg_state_e       conv_state;
  logic             conv_busy, conv_done;
  logic [BCD_W-1:0] conv_digits;

  assign cur_val = sif.src_val[cur_src*VAL_W +: VAL_W];
  assign advance = sif.mode_auto && ((dwell_cnt == DWELL_LAST) || sif.step);
  assign start   = !blank && ((cur_src != last_src) || (cur_val != snapshot));

  // Next valid index strictly after cur_src; a full wrap lands back on cur_src itself.
  always_comb begin
    next_src = cur_src;
    cand     = cur_src;
    found    = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SEL_W'((int'(cur_src) + k) % NUM_SRC);
      if (!found && sif.src_valid[cand]) begin
        next_src = cand;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_src   <= '0;
      last_src  <= '0;
      snapshot  <= '0;
      dwell_cnt <= '0;
      blank     <= 1'b1;
    end else begin
      blank <= ~sif.src_valid[cur_src];
      if (sif.mode_auto) begin
        if (advance) begin
          dwell_cnt <= '0;
          cur_src   <= next_src;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end else begin
        dwell_cnt <= '0;
        cur_src   <= sif.sel_manual;
      end
      // Snapshot tracks exactly what the engine latched, so a later change re-triggers.
      if (conv_state == LOAD) begin
        snapshot <= cur_val;
        last_src <= cur_src;
      end
    end
  end

  bcd_seq_conv #(.VAL_W(VAL_W)) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .value  (cur_val),
    .state  (conv_state),
    .busy   (conv_busy),
    .done   (conv_done),
    .digits (conv_digits)
  );

  assign sif.digits    = conv_digits;
  assign sif.cur_src   = cur_src;
  assign sif.blank     = blank;
  assign sif.busy      = conv_busy;
  assign sif.upd       = conv_done;
  assign sif.dbg_state = conv_state;

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Scheduler and configuration front-end for the four-digit seven-segment driver.
- Shares the single display between NUM_SRC debug sources (e.g. PC, instruction count, register value, cycle count).
- Selects a source either manually or by timed round-robin, converts its binary value to four BCD digits with a sequential double-dabble engine, and holds a stable digit word for the driver.
- Sits between the CPU debug taps / board switches and the display driver.

Parameters:
- NUM_SRC, 4, number of requesting sources (power of two, 2..8).
- VAL_W, 13, width of each source value; must be ≤ 13 so the maximum value is ≤ 9999.
- DWELL, 100_000_000, clk cycles each source is shown in auto mode; benches override to a small value such as 20.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- src_val  in  NUM_SRC*VAL_W  packed source values; source i occupies [i*VAL_W +: VAL_W]
- src_valid  in  NUM_SRC  source i has displayable data
- mode_auto  in  1  1 = timed round-robin, 0 = manual selection
- sel_manual  in  $clog2(NUM_SRC)  source index used in manual mode
- step  in  1  single-cycle pulse; advance to the next source (auto mode only)
- digits  out  16  {thous,hunds,tens,units} BCD digits
- cur_src  out  $clog2(NUM_SRC)  index of the source currently displayed
- blank  out  1  no valid source; driver should blank the display
- busy  out  1  conversion in progress
- upd  out  1  one-cycle pulse when digits is updated

Behaviour:
- Reset (rst=0 at posedge clk):
  - digits=0, cur_src=0, blank=1, busy=0, upd=0.
  - Dwell counter=0, FSM=IDLE, last-converted snapshot=0.
  - Reset mid-conversion aborts it; digits return to 0.
- Source selection:
  - Manual mode: cur_src follows sel_manual one cycle after the change.
  - Auto mode: the dwell counter increments every cycle. An advance occurs when it reaches DWELL-1 or when step=1. Both in the same cycle produce exactly one advance.
  - On an advance, the counter clears.
  - Advance picks the next index with src_valid=1, searching cur_src+1 upward and wrapping modulo NUM_SRC.
  - If only cur_src is valid, cur_src is kept.
  - Leaving auto mode clears the dwell counter.
- Blanking:
  - blank=1 whenever src_valid[cur_src]=0; it is registered, so it takes effect one cycle later.
  - While blank=1, no conversion starts and digits hold their last value.
  - In auto mode with cur_src invalid, the next advance also searches for a valid source.
- FSM states IDLE, LOAD, SHIFT, COMMIT:
  - IDLE → LOAD when blank=0 and (cur_src changed since the last commit, or the value of the current source ≠ snapshot).
  - LOAD (1 cycle):
    - Capture the value of the current source into the shift register and the snapshot.
    - Clear the 16-bit BCD accumulator.
    - Capture the source index.
    - Set busy=1.
  - SHIFT (VAL_W cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. An iteration counter counts 0..VAL_W-1.
  - COMMIT (1 cycle): digits ← accumulator, upd=1, busy=0, then → IDLE.
- Latency and stability:
  - digits update VAL_W+2 cycles after LOAD entry (15 for VAL_W=13).
  - Back-to-back conversion interval is VAL_W+3 cycles.
  - digits change only in COMMIT, so the driver never sees a partially converted word.
- Change during conversion:
  - A source change or value change mid-conversion does not abort it; the stale value is committed.
  - The IDLE check then starts a fresh conversion on the next cycle.
- Width rules:
  - The accumulator is 16 bits and the shift path is VAL_W+16 bits.
  - No overflow is possible for VAL_W ≤ 13.

Decomposition:
- Shared package seg_pkg:
  - FSM state enum: IDLE=0, LOAD=1, SHIFT=2, COMMIT=3.
  - BCD_W=16.
  - ADD3_THRESH=5.
- Sub-module bcd_seq_conv: LOAD/SHIFT/COMMIT engine with start/value in and busy/done/digits out.
- Source selection and dwell logic stay in the top.

Test Plan:
- Manual, sel_manual=2, src2=8191, all valid, release reset → upd at cycle 15 after LOAD; digits=16'h8191, cur_src=2.
- Manual, src1=0 then src1=4095 while busy → first commit digits=16'h0000; second conversion starts the next cycle; final digits=16'h4095.
- Auto, DWELL=20, src_valid=4'b1011, values 11/22/33/44 → cur_src sequence 0,1,3,0 every 20 cycles; digits 0011,0022,0044,0011.
- Auto, step pulse coincident with dwell expiry → single advance of one valid index; counter cleared.
- src_valid=0 → blank=1 after one cycle; busy stays 0; digits hold. Then set src_valid[0]=1 → blank=0 and conversion starts.
- rst=0 asserted mid-SHIFT → next cycle digits=0, busy=0, blank=1, cur_src=0; no upd pulse.
